rgb_byte_unpacker: RTL and testbench

//  Upstream stage of the brightness pixel path. Accepts a serial 8-bit byte stream (R,G,B per pixel).

---
 rtl/rgb_byte_unpacker.sv | 100 ++++++++++
 tb/tb_rgb_byte_unpacker.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rgb_byte_unpacker.sv
// Serial R,G,B byte stream to 24-bit pixel unpacker with valid/ready on both sides and sof/eol/eof tags.
// Define RGB_UNPACK_BGR_EN to take the byte order as B,G,R instead of R,G,B.
module rgb_byte_unpacker #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sof,
  output logic       eol,
  output logic       eof
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  localparam logic [1:0] PH_R = 2'd0;
  localparam logic [1:0] PH_G = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;

  logic [1:0]    phase;
  logic [7:0]    hold0, hold1;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept, load;

  // sync restarts the pixel at R, so a byte offered with it never waits on the output register
  always_comb begin
    in_ready = sync || (phase != PH_B) || !out_valid || out_ready;
    accept   = in_valid && in_ready;
    load     = accept && (phase == PH_B) && !sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PH_R;
      hold0     <= '0;
      hold1     <= '0;
      x         <= '0;
      y         <= '0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
    end else begin
      if (sync) begin
        phase <= accept ? PH_G : PH_R;
        hold0 <= accept ? in_data : 8'd0;
        hold1 <= '0;
        x     <= '0;
        y     <= '0;
      end else if (accept) begin
        case (phase)
          PH_R: begin hold0 <= in_data; phase <= PH_G; end
          PH_G: begin hold1 <= in_data; phase <= PH_B; end
          default: phase <= PH_R;
        endcase
      end

      if (load) begin
`ifdef RGB_UNPACK_BGR_EN
        r_out <= in_data;
        g_out <= hold1;
        b_out <= hold0;
`else
        r_out <= hold0;
        g_out <= hold1;
        b_out <= in_data;
`endif
        out_valid <= 1'b1;
        sof       <= (x == '0) && (y == '0);
        eol       <= (x == X_LAST);
        eof       <= (x == X_LAST) && (y == Y_LAST);
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_byte_unpacker.sv
// Directed-vector bench for rgb_byte_unpacker at IMG_W=4, IMG_H=2; honours RGB_UNPACK_BGR_EN for byte order.
module tb_rgb_byte_unpacker;
  logic       clk = 1'b0;
  logic       rst, sync, in_valid, in_ready, out_valid, out_ready, sof, eol, eof;
  logic [7:0] in_data, r_out, g_out, b_out;
  int         n_vec = 0;
  int         n_err = 0;

  rgb_byte_unpacker #(.IMG_W(4), .IMG_H(2)) dut (
    .clk(clk), .rst(rst), .sync(sync), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .out_valid(out_valid), .out_ready(out_ready), .sof(sof), .eol(eol), .eof(eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold the byte until accepted; leaves in_valid high so consecutive pushes are gapless.
  task automatic push(input logic [7:0] b);
    logic ok;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1 ok = in_ready;
      @(posedge clk); #1;
      if (ok) return;
    end
    chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // First byte lands in r_out for RGB order, in b_out for BGR order.
  task automatic chk_pix(input string tag, input logic [7:0] b0, b1, b2,
                         input logic s, input logic l, input logic f);
`ifdef RGB_UNPACK_BGR_EN
    chk({tag, "_r"}, r_out, b2);
    chk({tag, "_b"}, b_out, b0);
`else
    chk({tag, "_r"}, r_out, b0);
    chk({tag, "_b"}, b_out, b2);
`endif
    chk({tag, "_g"}, g_out, b1);
    chk({tag, "_v"}, out_valid, 1'b1);
    chk({tag, "_sof"}, sof, s);
    chk({tag, "_eol"}, eol, l);
    chk({tag, "_eof"}, eof, f);
  endtask

  initial begin
    in_data = '0; out_ready = 1'b1;
    do_reset();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_pix", {r_out, g_out, b_out}, 24'h0);
    chk("rst_marks", {sof, eol, eof}, 3'b000);

    // 1: basic pixel, one cycle latency, drops after handshake
    push(8'h11); push(8'h22); push(8'h33);
    in_valid = 1'b0;
    chk_pix("t1", 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t1_drop", out_valid, 1'b0);

    // 2: backpressure, then back-to-back reload
    out_ready = 1'b0;
    push(8'h44); push(8'h55); push(8'h66);
    push(8'h77); push(8'h88);
    in_data = 8'h99; in_valid = 1'b1;
    #1 chk("t2_stall_rdy", in_ready, 1'b0);
    tick(); tick();
    chk_pix("t2_hold", 8'h44, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0);
    chk("t2_stall_rdy2", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk("t2_rel_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_pix("t2_b2b", 8'h77, 8'h88, 8'h99, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_drop", out_valid, 1'b0);

    // 3: markers across a 4x2 frame and wrap
    do_reset();
    for (int p = 0; p < 9; p++) begin
      push(8'(p * 3 + 1)); push(8'(p * 3 + 2)); push(8'(p * 3 + 3));
      chk_pix($sformatf("t3_p%0d", p), 8'(p * 3 + 1), 8'(p * 3 + 2), 8'(p * 3 + 3),
              (p % 8) == 0, (p % 4) == 3, (p % 8) == 7);
    end
    in_valid = 1'b0;
    tick();

    // 4: sync drops a partial pixel and clears position
    do_reset();
    push(8'h01); push(8'h02); push(8'h03);
    push(8'hA1); push(8'hA2);
    in_valid = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0;
    push(8'hAA); push(8'hBB); push(8'hCC);
    in_valid = 1'b0;
    chk_pix("t4", 8'hAA, 8'hBB, 8'hCC, 1'b1, 1'b0, 1'b0);
    tick();

    // 4b: sync coinciding with a PH_B byte takes it as R, no pixel loads
    push(8'hB1); push(8'hB2);
    sync = 1'b1;
    push(8'hDD);
    sync = 1'b0;
    chk("t4b_noload", out_valid, 1'b0);
    push(8'hEE); push(8'hFF);
    in_valid = 1'b0;
    chk_pix("t4b", 8'hDD, 8'hEE, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();

    // 5: reset with a pending pixel and a partial one
    out_ready = 1'b0;
    push(8'h21); push(8'h22); push(8'h23);
    push(8'h24); push(8'h25);
    do_reset();
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_ready", in_ready, 1'b1);
    chk("t5_pix", {r_out, g_out, b_out}, 24'h0);
    out_ready = 1'b1;
    push(8'h31); push(8'h32); push(8'h33);
    in_valid = 1'b0;
    chk_pix("t5", 8'h31, 8'h32, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
